// File: rtl/mem_stage_responder_if.sv
// EX/MEM-to-responder bus: request side from the pipeline register, write-back side
// and the stall back to the pipeline.
interface mem_stage_responder_if;
    logic [31:0] dbus;
    logic [31:0] databus_in;
    logic [31:0] Dselect;
    logic        SW_MEM;
    logic        LW_MEM;
    logic [31:0] wb_data;
    logic [31:0] Dselect_WB;
    logic        LW_WB;
    logic        stall;

    modport master (
        output dbus, databus_in, Dselect, SW_MEM, LW_MEM,
        input  wb_data, Dselect_WB, LW_WB, stall
    );

    modport slave (
        input  dbus, databus_in, Dselect, SW_MEM, LW_MEM,
        output wb_data, Dselect_WB, LW_WB, stall
    );
endinterface

// File: rtl/mem_stage_responder.sv
// MEM-stage data-memory responder: word LW/SW against an internal RAM with
// WAIT_STATES extra cycles per access, stalling the upstream pipeline meanwhile.
module mem_stage_responder #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_stage_responder_if.slave  bus
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   hold_idx_q;
    logic [31:0]         hold_data_q;
    logic [31:0]         hold_dsel_q;
    logic                hold_sw_q;
    logic                latch_en;

    logic [31:0]         wb_data_q, wb_data_d;
    logic [31:0]         dsel_wb_q, dsel_wb_d;
    logic                lw_wb_q, lw_wb_d;

    logic [31:0]         ram_q [DEPTH];
    logic                ram_we;

    logic                req;
    logic [ADDR_W-1:0]   in_idx;
    logic                acc_en, acc_sw;
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         acc_data, acc_dsel;
    logic                stall_c;

    // Misalignment bits and address bits above the RAM depth are deliberately dropped.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{bus.dbus[31:ADDR_W+2], bus.dbus[1:0]};

    assign req    = bus.SW_MEM | bus.LW_MEM;
    assign in_idx = bus.dbus[ADDR_W+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_en  = 1'b0;
        stall_c   = 1'b0;
        acc_en    = 1'b0;
        acc_sw    = bus.SW_MEM;
        acc_idx   = in_idx;
        acc_data  = bus.databus_in;
        acc_dsel  = bus.Dselect;
        wb_data_d = bus.dbus;
        dsel_wb_d = bus.Dselect;
        lw_wb_d   = 1'b0;
        ram_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        acc_en = 1'b1;
                    end else begin
                        stall_c   = 1'b1;
                        latch_en  = 1'b1;
                        cnt_d     = CNT_INIT;
                        state_d   = S_WAIT;
                        wb_data_d = '0;
                        dsel_wb_d = '0;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall_c   = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                    wb_data_d = '0;
                    dsel_wb_d = '0;
                end else begin
                    // Complete from the latched copies; live inputs are ignored here.
                    acc_en   = 1'b1;
                    acc_sw   = hold_sw_q;
                    acc_idx  = hold_idx_q;
                    acc_data = hold_data_q;
                    acc_dsel = hold_dsel_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (acc_en) begin
            if (acc_sw) begin
                ram_we    = 1'b1;
                wb_data_d = '0;
                dsel_wb_d = '0;
            end else begin
                wb_data_d = ram_q[acc_idx];
                dsel_wb_d = acc_dsel;
                lw_wb_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            wb_data_q <= '0;
            dsel_wb_q <= '0;
            lw_wb_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            dsel_wb_q <= dsel_wb_d;
            lw_wb_q   <= lw_wb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            hold_idx_q  <= in_idx;
            hold_data_q <= bus.databus_in;
            hold_dsel_q <= bus.Dselect;
            hold_sw_q   <= bus.SW_MEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
        end else if (ram_we) begin
            ram_q[acc_idx] <= acc_data;
        end
    end

    assign bus.wb_data    = wb_data_q;
    assign bus.Dselect_WB = dsel_wb_q;
    assign bus.LW_WB      = lw_wb_q;
    // Held low during reset so the pipeline is never frozen by a stale strobe.
    assign bus.stall      = stall_c & rst_n;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Bench for mem_stage_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance checked
// against a word-array memory model.
module tb_mem_stage_responder;

    localparam int WS = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [31:0] mem2 [64];
    logic [31:0] mem0 [64];

    mem_stage_responder_if bus2 ();
    mem_stage_responder_if bus0 ();

    mem_stage_responder #(.ADDR_W(6), .WAIT_STATES(WS)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    mem_stage_responder #(.ADDR_W(6), .WAIT_STATES(0))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: memory is an array of words indexed by (byte address / 4) mod 64.
    task automatic model2(input logic sw, input logic lw, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] ds, output logic [31:0] e_wb, output logic [31:0] e_ds,
                          output logic e_lw, output int e_st);
        int idx;
        idx = int'((a / 32'd4) % 32'd64);
        if (sw) begin
            mem2[idx] = d; e_wb = 0; e_ds = 0; e_lw = 0; e_st = WS;
        end else if (lw) begin
            e_wb = mem2[idx]; e_ds = ds; e_lw = 1; e_st = WS;
        end else begin
            e_wb = a; e_ds = ds; e_lw = 0; e_st = 0;
        end
    endtask

    // Drive one instruction on bus2, count stall cycles, and capture the WB result.
    task automatic op2(input logic sw, input logic lw, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ds, output int nst, output bit bub_ok,
                       output logic [31:0] o_wb, output logic [31:0] o_ds, output logic o_lw);
        @(negedge clk);
        bus2.SW_MEM = sw; bus2.LW_MEM = lw; bus2.dbus = a; bus2.databus_in = d; bus2.Dselect = ds;
        #1;
        nst = 0; bub_ok = 1'b1;
        while (bus2.stall === 1'b1 && nst < 20) begin
            nst++;
            @(negedge clk); #1;
            if (bus2.wb_data !== 32'd0 || bus2.Dselect_WB !== 32'd0 || bus2.LW_WB !== 1'b0) bub_ok = 1'b0;
        end
        @(posedge clk); #1;
        o_wb = bus2.wb_data; o_ds = bus2.Dselect_WB; o_lw = bus2.LW_WB;
        bus2.SW_MEM = 0; bus2.LW_MEM = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus2.SW_MEM = 0; bus2.LW_MEM = 0; bus2.dbus = 32'h1234; bus2.databus_in = 0; bus2.Dselect = 32'h8;
        bus0.SW_MEM = 0; bus0.LW_MEM = 0; bus0.dbus = 32'h1234; bus0.databus_in = 0; bus0.Dselect = 32'h8;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 64; i++) begin mem2[i] = 0; mem0[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus2.wb_data !== 32'd0 || bus2.Dselect_WB !== 32'd0 || bus2.LW_WB !== 1'b0) begin
            n_err++; $display("FAIL reset_out2: got wb=%h ds=%h lw=%b want all 0", bus2.wb_data, bus2.Dselect_WB, bus2.LW_WB); end
        n_cmp++; if (bus0.wb_data !== 32'd0 || bus0.Dselect_WB !== 32'd0 || bus0.LW_WB !== 1'b0) begin
            n_err++; $display("FAIL reset_out0: got wb=%h ds=%h lw=%b want all 0", bus0.wb_data, bus0.Dselect_WB, bus0.LW_WB); end
        n_cmp++; if (bus2.stall !== 1'b0 || bus0.stall !== 1'b0) begin
            n_err++; $display("FAIL reset_stall: got %b/%b want 0/0", bus2.stall, bus0.stall); end
        bus2.dbus = 0; bus2.Dselect = 0; bus0.dbus = 0; bus0.Dselect = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        logic [31:0] a, ds, e_wb, e_ds, o_wb, o_ds; logic e_lw, o_lw; int e_st, nst; bit bub;
        for (int i = 0; i < 6; i++) begin
            a  = (i == 0) ? 32'h0000_1234 : $urandom;
            ds = (i == 0) ? 32'h0000_0008 : (32'd1 << $urandom_range(0, 31));
            model2(1'b0, 1'b0, a, 32'd0, ds, e_wb, e_ds, e_lw, e_st);
            op2(1'b0, 1'b0, a, 32'd0, ds, nst, bub, o_wb, o_ds, o_lw);
            n_cmp++; if (nst !== e_st) begin n_err++; $display("FAIL alu_stall[%0d]: got %0d want %0d", i, nst, e_st); end
            n_cmp++; if (o_wb !== e_wb || o_ds !== e_ds || o_lw !== e_lw) begin n_err++;
                $display("FAIL alu_wb[%0d]: got %h/%h/%b want %h/%h/%b", i, o_wb, o_ds, o_lw, e_wb, e_ds, e_lw); end
        end
    endtask

    // Fixed SW/LW pairs: plain read-back, address wrap/alignment, and both strobes high.
    task automatic test_sw_lw();
        logic [31:0] ta [6] = '{32'h10, 32'h10, 32'h104, 32'h6, 32'h20, 32'h20};
        logic [31:0] td [6] = '{32'hDEADBEEF, 0, 32'h5555AAAA, 0, 32'h77, 0};
        logic [31:0] tds[6] = '{32'h2, 32'h4, 32'h1, 32'h10, 32'h2, 32'h40};
        logic        tsw[6] = '{1, 0, 1, 0, 1, 0};
        logic        tlw[6] = '{0, 1, 0, 1, 1, 1};
        logic [31:0] e_wb, e_ds, o_wb, o_ds; logic e_lw, o_lw; int e_st, nst; bit bub;
        for (int i = 0; i < 6; i++) begin
            model2(tsw[i], tlw[i], ta[i], td[i], tds[i], e_wb, e_ds, e_lw, e_st);
            op2(tsw[i], tlw[i], ta[i], td[i], tds[i], nst, bub, o_wb, o_ds, o_lw);
            n_cmp++; if (nst !== e_st) begin n_err++; $display("FAIL mem_stall[%0d]: got %0d want %0d", i, nst, e_st); end
            n_cmp++; if (!bub) begin n_err++; $display("FAIL mem_bubble[%0d]: got non-bubble during stall want 0/0/0", i); end
            n_cmp++; if (o_wb !== e_wb || o_ds !== e_ds || o_lw !== e_lw) begin n_err++;
                $display("FAIL mem_wb[%0d]: got %h/%h/%b want %h/%h/%b", i, o_wb, o_ds, o_lw, e_wb, e_ds, e_lw); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, ds, e_wb, e_ds, o_wb, o_ds; logic e_lw, o_lw, sw, lw; int e_st, nst, k; bit bub;
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 3);
            sw = (k == 1 || k == 3); lw = (k == 2 || k == 3);
            a = $urandom; a[7:2] = 6'($urandom_range(0, 7));
            d = $urandom; ds = 32'd1 << $urandom_range(0, 31);
            model2(sw, lw, a, d, ds, e_wb, e_ds, e_lw, e_st);
            op2(sw, lw, a, d, ds, nst, bub, o_wb, o_ds, o_lw);
            n_cmp++; if (nst !== e_st || !bub) begin n_err++;
                $display("FAIL rnd_stall[%0d]: got %0d cycles bubble_ok=%b want %0d cycles bubble_ok=1", i, nst, bub, e_st); end
            n_cmp++; if (o_wb !== e_wb || o_ds !== e_ds || o_lw !== e_lw) begin n_err++;
                $display("FAIL rnd_wb[%0d]: got %h/%h/%b want %h/%h/%b", i, o_wb, o_ds, o_lw, e_wb, e_ds, e_lw); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e_wb, e_ds, o_wb, o_ds; logic e_lw, o_lw; int e_st, nst; bit bub;
        model2(1'b1, 1'b0, 32'h30, 32'h1111_1111, 32'h2, e_wb, e_ds, e_lw, e_st);
        op2(1'b1, 1'b0, 32'h30, 32'h1111_1111, 32'h2, nst, bub, o_wb, o_ds, o_lw);
        @(negedge clk);
        bus2.SW_MEM = 1; bus2.dbus = 32'h30; bus2.databus_in = 32'hCAFE_F00D; bus2.Dselect = 32'h2;
        @(negedge clk); #1;
        n_cmp++; if (bus2.stall !== 1'b1) begin n_err++; $display("FAIL midrst_pre_stall: got %b want 1", bus2.stall); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus2.stall !== 1'b0) begin n_err++; $display("FAIL midrst_stall: got %b want 0", bus2.stall); end
        n_cmp++; if (bus2.wb_data !== 32'd0 || bus2.Dselect_WB !== 32'd0 || bus2.LW_WB !== 1'b0) begin n_err++;
            $display("FAIL midrst_out: got %h/%h/%b want 0/0/0", bus2.wb_data, bus2.Dselect_WB, bus2.LW_WB); end
        bus2.SW_MEM = 0;
        for (int i = 0; i < 64; i++) begin mem2[i] = 0; mem0[i] = 0; end
        @(negedge clk); rst_n = 1'b1;
        model2(1'b0, 1'b1, 32'h30, 32'd0, 32'h4, e_wb, e_ds, e_lw, e_st);
        op2(1'b0, 1'b1, 32'h30, 32'd0, 32'h4, nst, bub, o_wb, o_ds, o_lw);
        n_cmp++; if (nst !== e_st) begin n_err++; $display("FAIL midrst_lw_stall: got %0d want %0d", nst, e_st); end
        n_cmp++; if (o_wb !== e_wb || o_ds !== e_ds || o_lw !== e_lw) begin n_err++;
            $display("FAIL midrst_lw: got %h/%h/%b want %h/%h/%b", o_wb, o_ds, o_lw, e_wb, e_ds, e_lw); end
    endtask

    // Single-cycle build: SW/LW alternate every cycle; each LW hits the preceding SW's word.
    task automatic test_ws0();
        logic [31:0] a, d, e_wb, e_ds; logic e_lw; bit have;
        have = 1'b0; a = 0; e_wb = 0; e_ds = 0; e_lw = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (have) begin
                n_cmp++; if (bus0.wb_data !== e_wb || bus0.Dselect_WB !== e_ds || bus0.LW_WB !== e_lw) begin n_err++;
                    $display("FAIL ws0_wb[%0d]: got %h/%h/%b want %h/%h/%b", i, bus0.wb_data, bus0.Dselect_WB, bus0.LW_WB, e_wb, e_ds, e_lw); end
            end
            if (i == 12) break;
            if (i % 2 == 0) begin
                a = $urandom; d = $urandom;
                bus0.SW_MEM = 1; bus0.LW_MEM = 0; bus0.dbus = a; bus0.databus_in = d;
                bus0.Dselect = 32'd1 << $urandom_range(0, 31);
                mem0[int'((a / 32'd4) % 32'd64)] = d;
                e_wb = 0; e_ds = 0; e_lw = 0;
            end else begin
                a = a ^ 32'hFFFF_FF03;
                bus0.SW_MEM = 0; bus0.LW_MEM = 1; bus0.dbus = a; bus0.databus_in = $urandom;
                bus0.Dselect = 32'd1 << i;
                e_wb = mem0[int'((a / 32'd4) % 32'd64)]; e_ds = 32'd1 << i; e_lw = 1;
            end
            have = 1'b1;
            #1;
            n_cmp++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL ws0_stall[%0d]: got %b want 0", i, bus0.stall); end
        end
        bus0.SW_MEM = 0; bus0.LW_MEM = 0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        test_reset();
        test_alu();
        test_sw_lw();
        test_random();
        test_reset_mid();
        test_ws0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_responder.md
Name: mem_stage_responder

Overview:
- Data-memory responder at the MEM stage; consumes the EX/MEM register outputs: address on dbus, store data on databus_in, destination select on Dselect, and the SW_MEM/LW_MEM strobes.
- Performs word loads/stores against an internal RAM with a configurable number of wait states.
- Asserts stall to freeze the upstream pipeline while an access is in progress.
- Drives the MEM/WB-side outputs: write-back data, destination select and load flag.

Parameters:
- ADDR_W, 6, log2 of RAM depth in 32-bit words (default 64 words).
- WAIT_STATES, 2, extra cycles per LW/SW access (0..15); 0 = single-cycle memory.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- dbus  input  32  byte address for LW/SW; ALU result for all other ops.
- databus_in  input  32  store data.
- Dselect  input  32  one-hot destination register select (0 = no write).
- SW_MEM  input  1  store request.
- LW_MEM  input  1  load request.
- wb_data  output  32  load data or passed-through ALU result.
- Dselect_WB  output  32  destination select to write-back.
- LW_WB  output  1  write-back value came from memory.
- stall  output  1  combinational; freeze PC, IF/ID, ID/EX and EX/MEM this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; wait counter = 0.
  - wb_data = 0, Dselect_WB = 0, LW_WB = 0, stall = 0.
  - All RAM words cleared to 0.
  - Any in-flight access is abandoned; a pending store is never written.
- Addressing:
  - Word index = dbus[ADDR_W+1:2].
  - dbus[1:0] is ignored (no misalignment trap).
  - Upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_W bytes.
- States: IDLE, WAIT.
- IDLE, neither strobe asserted (ALU op or bubble):
  - At the edge: wb_data <= dbus, Dselect_WB <= Dselect, LW_WB <= 0.
  - stall = 0.
- IDLE, LW_MEM or SW_MEM asserted in cycle T:
  - If SW_MEM and LW_MEM are both high, the access is treated as SW.
  - WAIT_STATES = 0:
    - Access completes at the edge ending cycle T; stall = 0.
    - SW: RAM[idx] <= databus_in; Dselect_WB <= 0; wb_data <= 0; LW_WB <= 0.
    - LW: wb_data <= RAM[idx]; Dselect_WB <= Dselect; LW_WB <= 1.
  - WAIT_STATES > 0:
    - stall = 1 in cycle T.
    - Address, data, Dselect and op are latched into holding registers.
    - Counter <= WAIT_STATES-1; state -> WAIT.
    - WB outputs at this edge: bubble (wb_data = 0, Dselect_WB = 0, LW_WB = 0).
- WAIT:
  - stall = 1 while counter != 0; the counter decrements each edge; WB outputs are bubbles each edge.
  - When counter == 0: stall = 0.
    - At that edge the access completes using the latched copies, with the same SW/LW updates as the single-cycle case; state -> IDLE.
    - Strobes on the inputs during WAIT are ignored. The frozen EX/MEM still shows the same instruction.
- Timing totals:
  - stall is high for exactly WAIT_STATES cycles per access.
  - Result is visible on the WB outputs after the edge ending cycle T+WAIT_STATES.
  - Back-to-back memory ops are accepted every WAIT_STATES+1 cycles.
- Read-after-write: a LW to the address just stored returns the new data, because the store completes before the next request can be accepted.
- Arithmetic: counter width is 4 bits; no other arithmetic; all data is 32-bit and unmodified.

Test Plan:
- Reset, then ALU op: dbus=0x0000_1234, Dselect=0x0000_0008, no strobes -> after 1 edge wb_data=0x1234, Dselect_WB=0x8, LW_WB=0, stall never high.
- WAIT_STATES=2: SW with dbus=0x10, databus_in=0xDEADBEEF in cycle T -> stall high in T and T+1, low in T+2. At the edge ending T+2, Dselect_WB=0 and LW_WB=0. Following LW dbus=0x10, Dselect=0x4 -> stall 2 cycles, then wb_data=0xDEADBEEF, Dselect_WB=0x4, LW_WB=1.
- Wrap/alignment (ADDR_W=6): SW 0x5555_AAAA to dbus=0x0000_0104, then LW dbus=0x0000_0006 -> wb_data=0x5555_AAAA; bits above index and [1:0] ignored.
- Both strobes high, dbus=0x20, databus_in=0x77 -> treated as SW: RAM[8]=0x77, Dselect_WB=0; a later LW of 0x20 returns 0x77.
- Reset mid-access: assert rst_n=0 in the second stall cycle of a SW to 0x30 -> stall drops immediately, outputs 0, state IDLE; a later LW of 0x30 returns 0.
- WAIT_STATES=0 build: alternating SW/LW every cycle -> stall never asserted; each LW returns the prior SW's data one edge later.
